// File: rtl/snake_pkg.sv
// Shared types and constants for the snake game controller: FSM states,
// direction encoding, PS/2 make codes and default grid size.
package snake_pkg;

  typedef enum logic [2:0] {
    ST_BLACK = 3'd0,
    ST_INIT  = 3'd1,
    ST_RUN   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DEAD  = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_e;

  localparam logic [7:0] KEY_UP    = 8'h75;
  localparam logic [7:0] KEY_DOWN  = 8'h72;
  localparam logic [7:0] KEY_LEFT  = 8'h6B;
  localparam logic [7:0] KEY_RIGHT = 8'h74;
  localparam logic [7:0] KEY_ENTER = 8'h5A;
  localparam logic [7:0] KEY_SPACE = 8'h29;
  localparam logic [7:0] KEY_ESC   = 8'h76;

  localparam int GRID_W_DEF = 64;
  localparam int GRID_H_DEF = 48;

  // Opposite directions differ only in bit 0 (UP/DOWN, LEFT/RIGHT).
  function automatic logic is_reverse(dir_e a, dir_e b);
    return (a ^ b) == 2'b01;
  endfunction

endpackage

// File: rtl/snake_game_ctrl_if.sv
// Signal bundle between the game controller and the snake datapath/pixel logic.
// Single-cycle pulse semantics: frame_pulse, key_valid, step and died are
// qualifiers valid for exactly the cycle they are high; there is no back-pressure.
interface snake_game_ctrl_if;
  logic       frame_pulse;
  logic       key_valid;
  logic [7:0] key_code;
  logic [6:0] head_x;
  logic [5:0] head_y;
  logic       self_hit;
  logic [2:0] state;
  logic       init_snake;
  logic       screen_black;
  logic       screen_pause;
  logic       step;
  logic [1:0] dir;
  logic       died;

  modport master (
    input  frame_pulse, key_valid, key_code, head_x, head_y, self_hit,
    output state, init_snake, screen_black, screen_pause, step, dir, died
  );

  modport slave (
    output frame_pulse, key_valid, key_code, head_x, head_y, self_hit,
    input  state, init_snake, screen_black, screen_pause, step, dir, died
  );
endinterface

// File: rtl/snake_step_timer.sv
// Frame divider: emits a one-cycle step after every FRAMES_PER_STEP counted
// frame pulses; the count holds while enable is low.
module snake_step_timer #(
  parameter int FRAMES_PER_STEP = 6
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic clear,
  input  logic frame_pulse,
  output logic step
);

  localparam logic [5:0] LAST = 6'(FRAMES_PER_STEP - 1);

  logic [5:0] count_q, count_d;
  logic       step_q, step_d;

  always_comb begin
    count_d = count_q;
    step_d  = 1'b0;
    if (clear) begin
      count_d = 6'd0;
    end else if (enable && frame_pulse) begin
      if (count_q == LAST) begin
        count_d = 6'd0;
        step_d  = 1'b1;
      end else begin
        count_d = count_q + 6'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 6'd0;
      step_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      step_q  <= step_d;
    end
  end

  assign step = step_q;

endmodule

// File: rtl/snake_game_ctrl.sv
// Snake game sequencer: game-state FSM, arrow-key direction latch with
// reversal protection, and wall/self collision checking after each step.
module snake_game_ctrl
  import snake_pkg::*;
#(
  parameter int FRAMES_PER_STEP = 6,
  parameter int GRID_W          = GRID_W_DEF,
  parameter int GRID_H          = GRID_H_DEF
) (
  input logic               clk,
  input logic               rst_n,
  snake_game_ctrl_if.master bus
);

  state_e state_q, state_d;
  dir_e   dir_q, dir_d, pend_q, pend_d;
  logic   check_q, check_d;
  logic   died_q, died_d;
  logic   step;
  logic   timer_en, timer_clr;

  logic   key_esc, key_enter, key_space, key_arrow, hit;
  dir_e   arrow_dir;

  always_comb begin
    key_esc   = bus.key_valid && (bus.key_code == KEY_ESC);
    key_enter = bus.key_valid && (bus.key_code == KEY_ENTER);
    key_space = bus.key_valid && (bus.key_code == KEY_SPACE);
    key_arrow = 1'b0;
    arrow_dir = DIR_RIGHT;
    if (bus.key_valid) begin
      unique case (bus.key_code)
        KEY_UP:    begin key_arrow = 1'b1; arrow_dir = DIR_UP;    end
        KEY_DOWN:  begin key_arrow = 1'b1; arrow_dir = DIR_DOWN;  end
        KEY_LEFT:  begin key_arrow = 1'b1; arrow_dir = DIR_LEFT;  end
        KEY_RIGHT: begin key_arrow = 1'b1; arrow_dir = DIR_RIGHT; end
        default:   key_arrow = 1'b0;
      endcase
    end
  end

  // check_q marks the cycle after a step, when the datapath shows the new head.
  assign hit = check_q && (state_q == ST_RUN) &&
               ((bus.head_x >= 7'(GRID_W)) || (bus.head_y >= 6'(GRID_H)) ||
                bus.self_hit);

  always_comb begin
    state_d = state_q;
    died_d  = 1'b0;
    unique case (state_q)
      ST_BLACK: if (key_enter) state_d = ST_INIT;
      ST_INIT:  state_d = ST_RUN;
      ST_RUN: begin
        if (hit) begin
          state_d = ST_DEAD;
          died_d  = 1'b1;
        end else if (key_space) begin
          state_d = ST_PAUSE;
        end
      end
      ST_PAUSE: if (key_space) state_d = ST_RUN;
      ST_DEAD:  if (key_enter) state_d = ST_INIT;
      default:  state_d = ST_BLACK;
    endcase
    if (key_esc) begin
      state_d = ST_BLACK;
      died_d  = 1'b0;
    end
  end

  // A step commits the pending direction held before this cycle's key.
  always_comb begin
    dir_d   = dir_q;
    pend_d  = pend_q;
    check_d = step && (state_q == ST_RUN);
    if (step) dir_d = pend_q;
    if ((state_q == ST_RUN) && key_arrow && !is_reverse(arrow_dir, dir_q))
      pend_d = arrow_dir;
    if (state_d == ST_INIT) begin
      dir_d  = DIR_RIGHT;
      pend_d = DIR_RIGHT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_BLACK;
      dir_q   <= DIR_RIGHT;
      pend_q  <= DIR_RIGHT;
      check_q <= 1'b0;
      died_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      pend_q  <= pend_d;
      check_q <= check_d;
      died_q  <= died_d;
    end
  end

  assign timer_en  = (state_q == ST_RUN);
  assign timer_clr = (state_d == ST_INIT);

  snake_step_timer #(
    .FRAMES_PER_STEP(FRAMES_PER_STEP)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (timer_en),
    .clear      (timer_clr),
    .frame_pulse(bus.frame_pulse),
    .step       (step)
  );

  assign bus.state        = state_q;
  assign bus.init_snake   = (state_q == ST_INIT);
  assign bus.screen_black = (state_q == ST_BLACK);
  assign bus.screen_pause = (state_q == ST_PAUSE) || (state_q == ST_DEAD);
  assign bus.step         = step;
  assign bus.dir          = dir_q;
  assign bus.died         = died_q;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Bench for snake_game_ctrl: hand-built vector table, reset corner case, and
// random play checked against a timestamp-based game model.
module tb_snake_game_ctrl;

  localparam int F = 6;

  localparam logic [2:0] S_BLACK = 3'd0;
  localparam logic [2:0] S_INIT  = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_PAUSE = 3'd3;
  localparam logic [2:0] S_DEAD  = 3'd4;

  localparam logic [7:0] K_UP = 8'h75, K_DOWN = 8'h72, K_LEFT = 8'h6B, K_RIGHT = 8'h74;
  localparam logic [7:0] K_ENTER = 8'h5A, K_SPACE = 8'h29, K_ESC = 8'h76;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  snake_game_ctrl_if bus ();

  snake_game_ctrl #(
    .FRAMES_PER_STEP(F)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [9:0] exp_q[$];

  // {state, init_snake, screen_black, screen_pause, step, dir, died}
  function automatic logic [9:0] exp_vec(logic [2:0] st, logic stp, logic [1:0] dr, logic dd);
    return {st, st == S_INIT, st == S_BLACK, (st == S_PAUSE) || (st == S_DEAD), stp, dr, dd};
  endfunction

  function automatic logic [9:0] act_vec();
    return {bus.state, bus.init_snake, bus.screen_black, bus.screen_pause,
            bus.step, bus.dir, bus.died};
  endfunction

  task automatic compare_out(input string name, input logic [9:0] exp);
    logic [9:0] act;
    act = act_vec();
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t actual st|init|blk|pau|step|dir|died=%b required=%b",
               name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Tracks game mode plus the absolute cycle numbers at which step and died show.
  int m_now = 0;
  int m_st, m_frames, m_dir, m_pend, m_step_at, m_died_at;
  bit m_step_run;
  int opp[4] = '{1, 0, 3, 2};

  function automatic void model_reset();
    m_st = 0; m_frames = 0; m_dir = 3; m_pend = 3;
    m_step_at = -10; m_died_at = -10; m_step_run = 1'b0;
  endfunction

  function automatic int arrow_of(logic [7:0] kc);
    case (kc)
      K_UP:    return 0;
      K_DOWN:  return 1;
      K_LEFT:  return 2;
      K_RIGHT: return 3;
      default: return -1;
    endcase
  endfunction

  function automatic logic [9:0] model_edge(logic fp, logic kv, logic [7:0] kc,
                                            logic [6:0] hx, logic [5:0] hy, logic sh);
    int nst, ad, new_dir;
    bit esc, ent, spc, hit;
    esc = kv && (kc == K_ESC);
    ent = kv && (kc == K_ENTER);
    spc = kv && (kc == K_SPACE);
    ad  = kv ? arrow_of(kc) : -1;
    hit = (m_st == 2) && m_step_run && (m_step_at == m_now - 1) &&
          ((int'(hx) >= 64) || (int'(hy) >= 48) || sh);
    new_dir = (m_step_at == m_now) ? m_pend : m_dir;
    if ((m_st == 2) && (ad >= 0) && (ad != opp[m_dir])) m_pend = ad;
    m_dir = new_dir;
    nst = m_st;
    case (m_st)
      0: if (ent) nst = 1;
      1: nst = 2;
      2: if (hit) nst = 4; else if (spc) nst = 3;
      3: if (spc) nst = 2;
      4: if (ent) nst = 1;
      default: nst = 0;
    endcase
    if (esc) nst = 0;
    if (hit && !esc) m_died_at = m_now + 1;
    if ((m_st == 2) && fp) begin
      m_frames++;
      if (m_frames == F) begin
        m_frames   = 0;
        m_step_at  = m_now + 1;
        m_step_run = (nst == 2);
      end
    end
    if ((nst == 1) && (m_st != 1)) begin
      m_frames = 0; m_dir = 3; m_pend = 3; m_step_at = -10;
    end
    m_st = nst;
    m_now++;
    return exp_vec(3'(m_st), m_step_at == m_now, 2'(m_dir), m_died_at == m_now);
  endfunction

  // ---------------- driver ----------------
  task automatic do_cycle(input logic fp, input logic [7:0] key, input logic [6:0] hx,
                          input logic [5:0] hy, input logic sh, input bit use_model,
                          input logic [9:0] texp, input string name);
    logic [9:0] mexp;
    bus.frame_pulse = fp;
    bus.key_valid   = (key != 8'h00);
    bus.key_code    = key;
    bus.head_x      = hx;
    bus.head_y      = hy;
    bus.self_hit    = sh;
    @(posedge clk);
    mexp = model_edge(fp, key != 8'h00, key, hx, hy, sh);
    exp_q.push_back(use_model ? mexp : texp);
    #1;
    compare_out(name, exp_q.pop_front());
  endtask

  task automatic idle_model(input logic fp, input logic [7:0] key, input string name);
    do_cycle(fp, key, 7'd10, 6'd10, 1'b0, 1'b1, 10'd0, name);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       fp;
    logic [7:0] key;
    logic [6:0] hx;
    logic [5:0] hy;
    logic       sh;
    logic [2:0] st;
    logic       stp;
    logic [1:0] dr;
    logic       dd;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(logic fp, logic [7:0] key, logic [6:0] hx, logic [5:0] hy,
                              logic sh, logic [2:0] st, logic stp, logic [1:0] dr, logic dd);
    vec_t v;
    v.fp = fp; v.key = key; v.hx = hx; v.hy = hy; v.sh = sh;
    v.st = st; v.stp = stp; v.dr = dr; v.dd = dd;
    tbl.push_back(v);
  endfunction

  function automatic void addk(logic fp, logic [7:0] key, logic [2:0] st, logic stp,
                               logic [1:0] dr, logic dd);
    add(fp, key, 7'd10, 6'd10, 1'b0, st, stp, dr, dd);
  endfunction

  initial begin
    bus.frame_pulse = 1'b0;
    bus.key_valid   = 1'b0;
    bus.key_code    = 8'h00;
    bus.head_x      = 7'd10;
    bus.head_y      = 6'd10;
    bus.self_hit    = 1'b0;
    model_reset();

    // start, LEFT ignored, UP coinciding with first step commits old RIGHT
    addk(0, K_ENTER, S_INIT, 0, 3, 0);
    addk(0, 8'h00,   S_RUN,  0, 3, 0);
    addk(1, K_LEFT,  S_RUN,  0, 3, 0);
    for (int i = 0; i < 4; i++) addk(1, 8'h00, S_RUN, 0, 3, 0);
    addk(1, 8'h00,   S_RUN,  1, 3, 0);
    addk(0, K_UP,    S_RUN,  0, 3, 0);
    for (int i = 0; i < 5; i++) addk(1, 8'h00, S_RUN, 0, 3, 0);
    addk(1, 8'h00,   S_RUN,  1, 3, 0);
    addk(0, 8'h00,   S_RUN,  0, 0, 0);
    // LEFT accepted against UP, then wall hit on X
    addk(1, K_LEFT,  S_RUN,  0, 0, 0);
    for (int i = 0; i < 4; i++) addk(1, 8'h00, S_RUN, 0, 0, 0);
    addk(1, 8'h00,   S_RUN,  1, 0, 0);
    addk(0, 8'h00,   S_RUN,  0, 2, 0);
    add (0, 8'h00, 7'd64, 6'd10, 0, S_DEAD, 0, 2, 1);
    addk(0, K_SPACE, S_DEAD, 0, 2, 0);
    addk(0, K_ENTER, S_INIT, 0, 3, 0);
    addk(0, 8'h00,   S_RUN,  0, 3, 0);
    // pause holds the frame count
    for (int i = 0; i < 3; i++) addk(1, 8'h00, S_RUN, 0, 3, 0);
    addk(0, K_SPACE, S_PAUSE, 0, 3, 0);
    for (int i = 0; i < 6; i++) addk(1, 8'h00, S_PAUSE, 0, 3, 0);
    addk(0, K_SPACE, S_RUN,  0, 3, 0);
    addk(1, 8'h00,   S_RUN,  0, 3, 0);
    addk(1, 8'h00,   S_RUN,  0, 3, 0);
    addk(1, 8'h00,   S_RUN,  1, 3, 0);
    addk(0, 8'h00,   S_RUN,  0, 3, 0);
    add (0, 8'h00, 7'd10, 6'd63, 0, S_DEAD, 0, 3, 1);
    // self hit
    addk(0, K_ENTER, S_INIT, 0, 3, 0);
    addk(0, 8'h00,   S_RUN,  0, 3, 0);
    for (int i = 0; i < 5; i++) addk(1, 8'h00, S_RUN, 0, 3, 0);
    addk(1, 8'h00,   S_RUN,  1, 3, 0);
    addk(0, 8'h00,   S_RUN,  0, 3, 0);
    add (0, 8'h00, 7'd10, 6'd10, 1, S_DEAD, 0, 3, 1);
    // ESC during a failing check: BLACK, no died pulse
    addk(0, K_ENTER, S_INIT, 0, 3, 0);
    addk(0, 8'h00,   S_RUN,  0, 3, 0);
    for (int i = 0; i < 5; i++) addk(1, 8'h00, S_RUN, 0, 3, 0);
    addk(1, 8'h00,   S_RUN,  1, 3, 0);
    addk(0, 8'h00,   S_RUN,  0, 3, 0);
    add (0, K_ESC, 7'd127, 6'd10, 0, S_BLACK, 0, 3, 0);
    addk(0, K_UP,    S_BLACK, 0, 3, 0);

    // reset state
    repeat (3) @(posedge clk);
    #1;
    compare_out("reset_state", exp_vec(S_BLACK, 1'b0, 2'd3, 1'b0));
    rst_n = 1'b1;

    foreach (tbl[i])
      do_cycle(tbl[i].fp, tbl[i].key, tbl[i].hx, tbl[i].hy, tbl[i].sh, 1'b0,
               exp_vec(tbl[i].st, tbl[i].stp, tbl[i].dr, tbl[i].dd), "table");

    // asynchronous reset while a step pulse is showing
    idle_model(0, K_ENTER, "rst_seq");
    idle_model(0, 8'h00, "rst_seq");
    idle_model(0, K_UP, "rst_seq");
    for (int i = 0; i < F; i++) idle_model(1, 8'h00, "rst_seq");
    rst_n = 1'b0;
    model_reset();
    #1;
    compare_out("async_reset", exp_vec(S_BLACK, 1'b0, 2'd3, 1'b0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) idle_model(0, 8'h00, "post_reset");

    // random play
    for (int i = 0; i < 3000; i++) begin
      logic       fp, sh;
      logic [7:0] key;
      logic [6:0] hx;
      logic [5:0] hy;
      int         r;
      fp  = ($urandom_range(0, 2) == 0);
      key = 8'h00;
      if ($urandom_range(0, 5) == 0) begin
        r = $urandom_range(0, 19);
        if (r < 8) begin
          case (r / 2)
            0: key = K_UP;
            1: key = K_DOWN;
            2: key = K_LEFT;
            default: key = K_RIGHT;
          endcase
        end else if (r < 10) key = K_ENTER;
        else if (r < 13) key = K_SPACE;
        else if (r == 13) key = K_ESC;
        else key = 8'($urandom_range(0, 255));
      end
      hx = ($urandom_range(0, 15) == 0) ? 7'($urandom_range(64, 127)) : 7'($urandom_range(0, 63));
      hy = ($urandom_range(0, 15) == 0) ? 6'($urandom_range(48, 63)) : 6'($urandom_range(0, 47));
      sh = ($urandom_range(0, 29) == 0);
      do_cycle(fp, key, hx, hy, sh, 1'b1, 10'd0, "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
